// File: rtl/fifo_dual_rd_port_fwft_pkg.sv
// Shared constants and helpers for the dual-read-port FWFT FIFO.
//   NUM_RD : number of independent read ports
//   ptr_w  : pointer width for a given depth (address bits + wrap bit)
package fifo_dual_rd_port_fwft_pkg;

    localparam int NUM_RD = 2;

    // One extra bit beyond the address so that "full" (wp - rp == DEPTH)
    // is distinguishable from "empty" (wp == rp).
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_dual_rd_port_fwft_ptr_cnt.sv
// Modulo pointer distance: cnt_o = wp_i - rp_i (mod 2^PW).
//   wp_i  : write pointer
//   rp_i  : read pointer
//   cnt_o : number of words ahead of the reader
module fifo_dual_rd_port_fwft_ptr_cnt #(
    parameter int PW = 5
) (
    input  logic [PW-1:0] wp_i,
    input  logic [PW-1:0] rp_i,
    output logic [PW-1:0] cnt_o
);

    // Unsigned wraparound gives the modulo-2*DEPTH distance for free.
    assign cnt_o = wp_i - rp_i;

endmodule

// File: rtl/fifo_dual_rd_port_fwft.sv
// Single-clock FWFT FIFO, one write port, two independent read ports.
// Each written word is delivered once to each read port; a slot is only
// reused after both readers have passed it.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   din       : write data
//   wr_en     : write request (ignored while full)
//   full      : slowest reader has DEPTH words pending
//   prog_full : slowest reader occupancy >= PROG_FULL
//   dout      : {port1, port0} head words, valid when the port is not empty
//   rd_en     : per-port pop (ignored while that port is empty)
//   empty     : per-port empty
module fifo_dual_rd_port_fwft
    import fifo_dual_rd_port_fwft_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int PROG_FULL = DEPTH - 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               din,
    input  logic                           wr_en,
    output logic                           full,
    output logic                           prog_full,
    output logic [NUM_RD-1:0][WIDTH-1:0]   dout,
    input  logic [NUM_RD-1:0]              rd_en,
    output logic [NUM_RD-1:0]              empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] PFULL_P = PW'(PROG_FULL);

    logic [PW-1:0]              wp_q, wp_d;
    logic [NUM_RD-1:0][PW-1:0]  rp_q, rp_d;
    logic [NUM_RD-1:0][PW-1:0]  cnt;
    logic [PW-1:0]              occ;
    logic                       wr_go;
    logic [WIDTH-1:0]           mem_q [DEPTH];

    // Per-port pending word counts.
    for (genvar i = 0; i < NUM_RD; i++) begin : gen_cnt
        fifo_dual_rd_port_fwft_ptr_cnt #(
            .PW (PW)
        ) u_cnt (
            .wp_i  (wp_q),
            .rp_i  (rp_q[i]),
            .cnt_o (cnt[i])
        );
        assign empty[i] = (cnt[i] == '0);
    end

    // Occupancy is governed by the slowest reader: it pins the oldest slot.
    assign occ       = (cnt[0] >= cnt[1]) ? cnt[0] : cnt[1];
    assign full      = (occ == DEPTH_P);
    assign prog_full = (occ >= PFULL_P);

    // Flags are sampled before the edge, so a same-cycle pop never lets a
    // write through while full.
    assign wr_go = wr_en & ~full;

    always_comb begin
        wp_d = wp_q;
        if (wr_go)
            wp_d = wp_q + PW'(1);
        for (int i = 0; i < NUM_RD; i++) begin
            rp_d[i] = rp_q[i];
            if (rd_en[i] & ~empty[i])
                rp_d[i] = rp_q[i] + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_go)
            mem_q[wp_q[AW-1:0]] <= din;
    end

    // First-word-fall-through: asynchronous read at each read pointer.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++)
            dout[i] = mem_q[rp_q[i][AW-1:0]];
    end

endmodule

// File: tb/tb_fifo_dual_rd_port_fwft.sv
module tb_fifo_dual_rd_port_fwft;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [WIDTH-1:0]      din;
    logic                  wr_en;
    logic                  full;
    logic                  prog_full;
    logic [1:0][WIDTH-1:0] dout;
    logic [1:0]            rd_en;
    logic [1:0]            empty;

    fifo_dual_rd_port_fwft #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .PROG_FULL (DEPTH - 1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .wr_en     (wr_en),
        .full      (full),
        .prog_full (prog_full),
        .dout      (dout),
        .rd_en     (rd_en),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue of pending words per read port.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    // Words actually popped per port (for the ordering check).
    logic [WIDTH-1:0] got0[$];
    logic [WIDTH-1:0] got1[$];

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] d;
        logic [1:0]       rd;
        logic [1:0]       e_empty;
        logic             e_full;
        logic [WIDTH-1:0] e_d0;
        logic [WIDTH-1:0] e_d1;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int occ_m();
        return (q0.size() > q1.size()) ? q0.size() : q1.size();
    endfunction

    task automatic check_model();
        chk("empty", {62'd0, empty}, {62'd0, q1.size() == 0, q0.size() == 0});
        chk("full", {63'd0, full}, {63'd0, occ_m() == DEPTH});
        chk("prog_full", {63'd0, prog_full}, {63'd0, occ_m() >= DEPTH - 1});
        if (q0.size() != 0) chk("dout0", {32'd0, dout[0]}, {32'd0, q0[0]});
        if (q1.size() != 0) chk("dout1", {32'd0, dout[1]}, {32'd0, q1[0]});
    endtask

    // Apply one cycle of stimulus; the model decides from pre-edge state.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic [1:0] r);
        logic push, pop0, pop1;
        wr_en = w;
        din   = d;
        rd_en = r;
        push  = w && (occ_m() < DEPTH);
        pop0  = r[0] && (q0.size() != 0);
        pop1  = r[1] && (q1.size() != 0);
        @(posedge clk);
        if (pop0) got0.push_back(q0.pop_front());
        if (pop1) got1.push_back(q1.pop_front());
        if (push) begin
            q0.push_back(d);
            q1.push_back(d);
        end
        #1;
        check_model();
    endtask

    initial begin
        int p0, p1, bad0, bad1;

        rst_n = 1'b0;
        wr_en = 1'b0;
        din   = '0;
        rd_en = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_empty", {62'd0, empty}, 64'h3);
        chk("rst_full", {63'd0, full}, 64'h0);
        chk("rst_pfull", {63'd0, prog_full}, 64'h0);

        // Single word, per-port pops, ignored reads on empty, write with read.
        tbl[0] = '{1'b1, 32'hA5, 2'b00, 2'b00, 1'b0, 32'hA5, 32'hA5};
        tbl[1] = '{1'b0, 32'h0,  2'b01, 2'b01, 1'b0, 32'h0,  32'hA5};
        tbl[2] = '{1'b0, 32'h0,  2'b10, 2'b11, 1'b0, 32'h0,  32'h0};
        tbl[3] = '{1'b0, 32'h0,  2'b11, 2'b11, 1'b0, 32'h0,  32'h0};
        tbl[4] = '{1'b0, 32'h0,  2'b11, 2'b11, 1'b0, 32'h0,  32'h0};
        tbl[5] = '{1'b0, 32'h0,  2'b11, 2'b11, 1'b0, 32'h0,  32'h0};
        tbl[6] = '{1'b0, 32'h0,  2'b11, 2'b11, 1'b0, 32'h0,  32'h0};
        tbl[7] = '{1'b1, 32'h3C, 2'b11, 2'b00, 1'b0, 32'h3C, 32'h3C};
        tbl[8] = '{1'b0, 32'h0,  2'b10, 2'b10, 1'b0, 32'h3C, 32'h0};
        tbl[9] = '{1'b0, 32'h0,  2'b01, 2'b11, 1'b0, 32'h0,  32'h0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].rd);
            chk($sformatf("tbl%0d_empty", i), {62'd0, empty}, {62'd0, tbl[i].e_empty});
            chk($sformatf("tbl%0d_full", i), {63'd0, full}, {63'd0, tbl[i].e_full});
            if (!tbl[i].e_empty[0]) chk($sformatf("tbl%0d_d0", i), {32'd0, dout[0]}, {32'd0, tbl[i].e_d0});
            if (!tbl[i].e_empty[1]) chk($sformatf("tbl%0d_d1", i), {32'd0, dout[1]}, {32'd0, tbl[i].e_d1});
        end

        // Skewed ports: port 1 stalls, so it fills after 16 writes.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 2'b01);
        chk("skew_full", {63'd0, full}, 64'h1);
        step(1'b1, 32'hDEAD, 2'b01);
        chk("skew_17th_ignored", {63'd0, full}, 64'h1);
        chk("skew_head1", {32'd0, dout[1]}, 64'h0);
        step(1'b0, 32'h0, 2'b10);
        chk("skew_recover", {63'd0, full}, 64'h0);
        step(1'b1, 32'h77, 2'b00);
        chk("skew_refill", {63'd0, full}, 64'h1);
        repeat (DEPTH + 2) step(1'b0, 32'h0, 2'b11);

        // Continuous drain: one word per cycle per port, in order.
        got0.delete();
        got1.delete();
        for (int i = 0; i < 100; i++) step(1'b1, 32'(i), 2'b11);
        step(1'b0, 32'h0, 2'b11);
        chk("drain_n0", 64'(got0.size()), 64'd100);
        chk("drain_n1", 64'(got1.size()), 64'd100);
        bad0 = 0;
        bad1 = 0;
        for (int i = 0; i < got0.size(); i++) if (got0[i] != 32'(i)) bad0++;
        for (int i = 0; i < got1.size(); i++) if (got1[i] != 32'(i)) bad1++;
        chk("drain_order0", 64'(bad0), 64'd0);
        chk("drain_order1", 64'(bad1), 64'd0);

        // Random traffic with per-port stall profiles; includes a mid-run reset.
        for (int c = 0; c < 500; c++) begin
            case (c / 125)
                0: begin p0 = 80; p1 = 20; end
                1: begin p0 = 20; p1 = 80; end
                2: begin p0 = 60; p1 = 60; end
                default: begin p0 = 90; p1 = 90; end
            endcase
            if (c == 300) begin
                rst_n = 1'b0;
                #2;
                chk("arst_empty", {62'd0, empty}, 64'h3);
                chk("arst_full", {63'd0, full}, 64'h0);
                chk("arst_pfull", {63'd0, prog_full}, 64'h0);
                q0.delete();
                q1.delete();
                wr_en = 1'b0;
                rd_en = 2'b00;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                check_model();
            end
            step($urandom_range(0, 99) < 75, $urandom,
                 {$urandom_range(0, 99) < p1, $urandom_range(0, 99) < p0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
